// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with generic operand width.
// Single-cycle logic/arithmetic ops plus a multi-cycle restoring divider
// that returns quotient (low half of y) and remainder (high half of y).
// One operation is in flight at a time.
// in_ready is high only in IDLE. out_valid is high only in DONE.

module alu_seq #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   y,
    output logic             zero,
    output logic             div_zero
);

    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_NOTB = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Divider working registers
    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_quot;
    logic [W-1:0]       r_divisor;
    logic [CW-1:0]      r_cnt;

    // Result registers
    logic [2*W-1:0]     r_y;
    logic               r_zero;
    logic               r_div_zero;

    // Handshake / control decodes
    logic               w_accept;
    logic               w_b_is_zero;
    logic               w_div_start;
    logic               w_div_last;
    logic               w_done_take;

    // Single-cycle datapath
    logic [W-1:0]       w_and;
    logic [W-1:0]       w_or;
    logic [W-1:0]       w_xor;
    logic [W-1:0]       w_nota;
    logic [W-1:0]       w_notb;
    logic [2*W-1:0]     w_a_ext;
    logic [2*W-1:0]     w_b_ext;
    logic [2*W-1:0]     w_imm_y;
    logic               w_imm_div_zero;

    // Divider step datapath
    logic [W:0]         w_shift;
    logic               w_ge;
    logic [W-1:0]       w_diff;
    logic [W-1:0]       w_rem_next;
    logic [W-1:0]       w_quot_next;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign y         = r_y;
    assign zero      = r_zero;
    assign div_zero  = r_div_zero;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_b_is_zero = (b == '0);
    // A divide by zero skips the DIV state and completes like any other single-cycle op.
    assign w_div_start = w_accept && (op == OP_DIV) && !w_b_is_zero;
    assign w_div_last  = (r_state == S_DIV) && (r_cnt == CW'(1));
    assign w_done_take = (r_state == S_DONE) && out_ready;

    // Per-bit logic unit
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_logic_bit
            assign w_and[gi]  = a[gi] & b[gi];
            assign w_or[gi]   = a[gi] | b[gi];
            assign w_xor[gi]  = a[gi] ^ b[gi];
            assign w_nota[gi] = ~a[gi];
            assign w_notb[gi] = ~b[gi];
        end
    endgenerate

    assign w_a_ext = {{W{1'b0}}, a};
    assign w_b_ext = {{W{1'b0}}, b};

    // Result of every operation that completes at the acceptance edge
    always_comb begin
        w_imm_y        = '0;
        w_imm_div_zero = 1'b0;
        case (op)
            OP_AND:  w_imm_y = {{W{1'b0}}, w_and};
            // Full 2W-bit subtraction so a < b yields all-ones in the upper half
            OP_SUB:  w_imm_y = w_a_ext - w_b_ext;
            OP_ADD:  w_imm_y = w_a_ext + w_b_ext;
            OP_OR:   w_imm_y = {{W{1'b0}}, w_or};
            OP_XOR:  w_imm_y = {{W{1'b0}}, w_xor};
            // Only reached here with b == 0; a nonzero divisor goes through the DIV state
            OP_DIV:  begin
                w_imm_y        = '0;
                w_imm_div_zero = 1'b1;
            end
            OP_NOTA: w_imm_y = {{W{1'b0}}, w_nota};
            OP_NOTB: w_imm_y = {{W{1'b0}}, w_notb};
            default: w_imm_y = '0;
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, then subtract if it fits.
    // The difference is computed in W bits.
    // When it is taken (w_ge), it is below the divisor, so it always fits in W bits.
    always_comb begin
        w_shift     = {r_rem, r_quot[W-1]};
        w_ge        = (w_shift >= {1'b0, r_divisor});
        w_diff      = w_shift[W-1:0] - r_divisor;
        w_rem_next  = w_ge ? w_diff : w_shift[W-1:0];
        w_quot_next = {r_quot[W-2:0], w_ge};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    // Leaving DONE always passes through IDLE, so nothing is accepted on the release edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_div_start) begin
                    w_state_next = S_DIV;
                end else if (w_accept) begin
                    w_state_next = S_DONE;
                end
            end
            S_DIV: begin
                if (w_div_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_done_take) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Divider registers.
    // The operands are captured at acceptance; later input changes do not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
        end else if (w_div_start) begin
            r_rem     <= '0;
            r_quot    <= a;
            r_divisor <= b;
            r_cnt     <= CW'(W);
        end else if (r_state == S_DIV) begin
            r_rem     <= w_rem_next;
            r_quot    <= w_quot_next;
            r_cnt     <= r_cnt - 1'b1;
        end
    end

    // Result and flag registers.
    // They are loaded only when entering DONE and otherwise hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y        <= '0;
            r_zero     <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept && !w_div_start) begin
            r_y        <= w_imm_y;
            r_zero     <= (w_imm_y == '0);
            r_div_zero <= w_imm_div_zero;
        end else if (w_div_last) begin
            r_y        <= {w_rem_next, w_quot_next};
            r_zero     <= ({w_rem_next, w_quot_next} == '0);
            r_div_zero <= 1'b0;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Operand width is generic, and inputs and outputs use valid/ready handshakes.
- Divide is a multi-cycle restoring divider that returns both quotient and remainder.
- Adds zero and divide-by-zero status flags.
- Sits between an operand producer and a result consumer on the same clock domain.

Parameters:
- W, 4, operand width in bits (W >= 2); result width is 2*W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand/opcode present.
- in_ready  output  1  block can accept a new operation.
- a  input  W  operand A.
- b  input  W  operand B.
- op  input  3  opcode: 0 AND, 1 SUB, 2 ADD, 3 OR, 4 XOR, 5 DIV, 6 NOT A, 7 NOT B.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer takes result.
- y  output  2*W  result.
- zero  output  1  y == 0 for the current result.
- div_zero  output  1  DIV with b == 0.

Behaviour:
- Reset (synchronous, rst=1 at an edge) sets:
  - state = IDLE, in_ready = 1 (combinational from state);
  - out_valid = 0, y = 0, zero = 0, div_zero = 0;
  - divider registers cleared.
- rst overrides every other event, including a DIV in progress and a pending unconsumed result; that result is lost.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - DIV: in_ready = 0, out_valid = 0, one quotient bit per cycle.
  - DONE: in_ready = 0, out_valid = 1; y and flags stable.
- Acceptance:
  - An operation is accepted on an edge where in_valid && in_ready.
  - a, b and op are registered at that edge; later input changes have no effect on it.
- Non-DIV op, or DIV with b == 0:
  - IDLE -> DONE at the acceptance edge.
  - out_valid is high in the cycle immediately following the acceptance cycle (latency 1).
- DIV with b != 0:
  - IDLE -> DIV at the acceptance edge; bit counter loaded with W.
  - Restoring division, MSB first, one step per edge for W edges.
  - The W-th step edge moves DIV -> DONE, so out_valid first rises W+1 cycles after the acceptance cycle.
- DONE -> IDLE on an edge where out_valid && out_ready.
  - out_valid drops the next cycle.
  - A new operation cannot be accepted in that same edge; peak throughput is 1 op per 2 cycles (non-DIV).
- out_ready low in DONE holds y, zero and div_zero indefinitely.
- in_valid while not in IDLE is ignored; the producer must hold it.
- Arithmetic (a and b are unsigned; results zero-extended to 2*W unless noted):
  - AND/OR/XOR: bitwise op in the low W bits, upper W bits 0.
  - ADD: a + b, carry lands in bit W.
  - SUB: (a - b) mod 2^(2W), i.e. 2W-bit two's complement; a < b gives upper bits all 1.
  - DIV: y[W-1:0] = quotient, y[2W-1:W] = remainder.
  - DIV with b == 0: y = 0, div_zero = 1; no DIV state is entered.
  - NOT A: ~a in the low W bits. NOT B: ~b in the low W bits.
- Flags:
  - zero = (y == 0), registered alongside y.
  - div_zero = 1 only for a DIV by zero, else 0.
  - Both flags are valid only while out_valid = 1.
- y and flags keep their last values in IDLE; they update only when entering DONE.

Test Plan:
- Reset, then W=4, op=2, a=9, b=3 accepted -> next cycle out_valid=1, y=8'h0C, zero=0; out_ready=1 -> IDLE, in_ready=1.
- op=1, a=3, b=5 -> y=8'hFE, zero=0. Then op=0, a=4'hA, b=4'h5 -> y=8'h00, zero=1.
- op=5, a=13, b=4 -> in_ready=0 for 4 DIV cycles; out_valid rises 5 cycles after the acceptance cycle with y=8'h13 (remainder 1, quotient 3).
- op=5, a=7, b=0 -> out_valid the next cycle, y=0, div_zero=1, zero=1. Then op=7, b=4'h5 -> y=8'h0A, div_zero=0.
- Backpressure: out_ready=0 for 3 cycles in DONE, with a, b, op and in_valid toggled -> y, flags and out_valid stable and in_ready=0; the result is released on the first out_ready=1.
- rst=1 asserted two cycles into a DIV of 15/2 -> the next cycle shows IDLE, out_valid=0, y=0; a subsequent op=2, a=1, b=1 gives y=8'h02.
